dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 32, the byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the word width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req  input  2  per-port access request, bit i = port i (port 0 CPU, port 1 loader/DMA).
REQ-007 we  input  2  per-port write enable.
REQ-008 byteop  input  2  per-port byte access (1) or word access (0).
REQ-009 addr  input  2xADDRESS_WIDTH  per-port byte address, packed [1:0][ADDRESS_WIDTH-1:0].
REQ-010 wdata  input  2xDATA_WIDTH  per-port write data, packed [1:0][DATA_WIDTH-1:0].
REQ-011 gnt  output  2  one-cycle grant pulse, one-hot or zero.
REQ-012 rvalid  output  2  one-cycle response pulse to the served port.
REQ-013 rdata  output  DATA_WIDTH  response data, shared by both ports, qualified by rvalid.
REQ-014 err  output  1  misaligned word access flag, qualified by rvalid.
REQ-015 mem_we, mem_byteop  output  1 each  to data memory.
REQ-016 mem_addr  output  ADDRESS_WIDTH; mem_wdata  output  DATA_WIDTH  to data memory.
REQ-017 mem_rdata  input  DATA_WIDTH  combinational read data from memory.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-019 In IDLE or RESP with any req bit set, the arbiter SHALL select a port, capture that port's we/byteop/addr/wdata into registers, and enter ACCESS next cycle. Otherwise it SHALL enter IDLE.
REQ-020 Selection SHALL be round-robin. A single requester wins. On simultaneous requests, the port not served last wins.
REQ-021 In ACCESS, gnt[sel] SHALL be 1 and mem_* SHALL be driven from the captured registers. Next state SHALL be RESP.
REQ-022 mem_we SHALL be 1 only in ACCESS with captured we=1, no misalignment and rst=0. Outside ACCESS, mem_* SHALL be 0.
REQ-023 In ACCESS, mem_rdata SHALL be registered into rdata; for a byte read, only bits [7:0] are valid.
REQ-024 In RESP, rvalid[sel] SHALL be 1, and rdata/err SHALL hold the captured result until the next RESP.
REQ-025 Latency: req sampled at edge N, gnt in cycle N+1, rvalid in cycle N+2. Back-to-back throughput SHALL be one access per 2 cycles.
REQ-026 Requesters SHALL hold req and attributes stable until gnt. A req dropped before selection is ignored.
REQ-027 Misalignment (byteop=0, addr[1:0]!=0) SHALL suppress the memory write and force rdata=0 and err=1 at RESP.
REQ-028 A write response SHALL return rvalid with rdata=0 and err=0 (or err=1 if misaligned).
REQ-029 The last-served pointer SHALL update when entering ACCESS.

Reset
REQ-030 While rst=1: state=IDLE, gnt=0, rvalid=0, rdata=0, err=0, mem_*=0, last-served=1 (so port 0 wins the first tie).
REQ-031 Reset asserted in ACCESS or RESP SHALL abort the access: no write that cycle and no rvalid afterwards.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the port index constants PORT_CPU=0 and PORT_AUX=1.
REQ-033 One sub-module, rr_arb2, SHALL implement the 2-way round-robin pick from req and last-served.

Verification
REQ-034 Port 0 word write addr 0x10000 data 0xDEADBEEF, then word read 0x10000 -> gnt[0] at N+1, rvalid[0] at N+2 with rdata=0xDEADBEEF.
REQ-035 Both ports request continuously -> grants alternate 0,1,0,1, with gnt[0] first after reset.
REQ-036 Port 1 byte write 0x10002 data 0xAB, then port 0 word read 0x10000 -> rdata=0xDEADABEF (big-endian byte 2).
REQ-037 Port 0 word write addr 0x10001 -> mem_we stays 0, err=1, rdata=0, and memory is unchanged on a later read.
REQ-038 rst pulsed in the ACCESS cycle of a write of 0x12345678 to 0x10004 -> mem_we=0, no rvalid, and a later read returns the old value.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state encoding, the port indices and the alignment helper.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    localparam int PORT_CPU = 0;
    localparam int PORT_AUX = 1;

    // A word access must sit on a 4-byte boundary; byte accesses never fault.
    function automatic logic is_misaligned(input logic byteop, input logic [1:0] addr_lo);
        return (!byteop) && (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, and on a tie the port
// that was not served last wins.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       pick
);

    always_comb begin
        valid = |req;
        pick  = 1'b0;
        if (req == 2'b11) begin
            pick = ~last;
        end else if (req[PORT_AUX]) begin
            pick = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU (port 0) and loader/DMA (port 1) accesses onto a single data
// memory port: select/capture, one ACCESS cycle, one RESP cycle.
//
// state  | meaning
// IDLE   | no access in flight; a request is captured here
// ACCESS | memory driven from captured request, grant pulsed, read data sampled
// RESP   | response pulsed to served port; a new request may be captured
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    req,
    input  logic [1:0]                    we,
    input  logic [1:0]                    byteop,
    input  logic [1:0][ADDRESS_WIDTH-1:0] addr,
    input  logic [1:0][DATA_WIDTH-1:0]    wdata,
    output logic [1:0]                    gnt,
    output logic [1:0]                    rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          err,
    output logic                          mem_we,
    output logic                          mem_byteop,
    output logic [ADDRESS_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    arb_state_e                 state_q, state_d;
    logic                       sel_q, sel_d;
    logic                       last_q, last_d;
    logic                       we_q, we_d;
    logic                       byteop_q, byteop_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       err_q, err_d;

    logic arb_valid;
    logic arb_pick;
    logic mis;

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (last_q),
        .valid (arb_valid),
        .pick  (arb_pick)
    );

    assign mis = is_misaligned(byteop_q, addr_q[1:0]);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        we_d       = we_q;
        byteop_d   = byteop_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        gnt        = '0;
        rvalid     = '0;
        mem_we     = 1'b0;
        mem_byteop = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (state_q == ST_RESP) begin
                    rvalid[sel_q] = 1'b1;
                end
                if (arb_valid) begin
                    state_d  = ST_ACCESS;
                    sel_d    = arb_pick;
                    last_d   = arb_pick;
                    we_d     = we[arb_pick];
                    byteop_d = byteop[arb_pick];
                    addr_d   = addr[arb_pick];
                    wdata_d  = wdata[arb_pick];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                gnt[sel_q] = 1'b1;
                mem_we     = we_q && !mis;
                mem_byteop = byteop_q;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                // Writes and faulting accesses report zero data; byte reads keep only the low lane.
                rdata_d = '0;
                if (!we_q && !mis) begin
                    if (byteop_q) begin
                        rdata_d[7:0] = mem_rdata[7:0];
                    end else begin
                        rdata_d = mem_rdata;
                    end
                end
                err_d   = mis;
                state_d = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset is synchronous, so the in-flight cycle must be silenced combinationally.
        if (rst) begin
            gnt        = '0;
            rvalid     = '0;
            mem_we     = 1'b0;
            mem_byteop = 1'b0;
            mem_addr   = '0;
            mem_wdata  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            byteop_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            we_q     <= we_d;
            byteop_q <= byteop_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small big-endian word memory model.
module tb_dmem_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [1:0]        byteop;
    logic [1:0][31:0]  addr;
    logic [1:0][31:0]  wdata;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [31:0]       rdata;
    logic              err;
    logic              mem_we;
    logic              mem_byteop;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:15];
    logic        mem_clr;
    logic [3:0]  midx;

    dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .byteop     (byteop),
        .addr       (addr),
        .wdata      (wdata),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .err        (err),
        .mem_we     (mem_we),
        .mem_byteop (mem_byteop),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign midx = mem_addr[5:2];

    // Byte 0 of a word lives in bits [31:24].
    always_comb begin
        mem_rdata = mem[midx];
        if (mem_byteop) begin
            mem_rdata = '0;
            case (mem_addr[1:0])
                2'd0: mem_rdata[7:0] = mem[midx][31:24];
                2'd1: mem_rdata[7:0] = mem[midx][23:16];
                2'd2: mem_rdata[7:0] = mem[midx][15:8];
                default: mem_rdata[7:0] = mem[midx][7:0];
            endcase
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (mem_we) begin
            if (mem_byteop) begin
                case (mem_addr[1:0])
                    2'd0: mem[midx][31:24] <= mem_wdata[7:0];
                    2'd1: mem[midx][23:16] <= mem_wdata[7:0];
                    2'd2: mem[midx][15:8]  <= mem_wdata[7:0];
                    default: mem[midx][7:0] <= mem_wdata[7:0];
                endcase
            end else begin
                mem[midx] <= mem_wdata;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the DUT in IDLE or RESP; returns #1 into the RESP cycle.
    task automatic do_access(input int port, input logic w, input logic b,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_rdata, input logic exp_err,
                             input logic exp_mem_we);
        logic [1:0] onehot;
        onehot       = 2'b01 << port;
        req          = '0;
        req[port]    = 1'b1;
        we[port]     = w;
        byteop[port] = b;
        addr[port]   = a;
        wdata[port]  = d;
        @(posedge clk); #1;
        check("acc_gnt", gnt, onehot);
        check("acc_rvalid_low", rvalid, 2'b00);
        check("acc_mem_we", mem_we, exp_mem_we);
        check("acc_mem_addr", mem_addr, a);
        if (exp_mem_we) check("acc_mem_wdata", mem_wdata, d);
        req = '0;
        @(posedge clk); #1;
        check("resp_rvalid", rvalid, onehot);
        check("resp_gnt_low", gnt, 2'b00);
        check("resp_mem_we_low", mem_we, 1'b0);
        check("resp_rdata", rdata, exp_rdata);
        check("resp_err", err, exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        mem_clr = 1'b1;
        req     = '0;
        we      = '0;
        byteop  = '0;
        addr    = '0;
        wdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 2'b00);
        check("rst_rvalid", rvalid, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", err, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        rst     = 1'b0;
        mem_clr = 1'b0;

        // Continuous requests from both ports alternate, CPU first.
        addr[0] = 32'h10000;
        addr[1] = 32'h10000;
        req     = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rr_gnt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            @(posedge clk); #1;
            check("rr_rvalid", rvalid, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i == 3) req = '0;
        end

        do_access(0, 1'b1, 1'b0, 32'h10000, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        do_access(0, 1'b0, 1'b0, 32'h10000, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        do_access(1, 1'b1, 1'b1, 32'h10002, 32'h000000AB, 32'h0, 1'b0, 1'b1);
        do_access(0, 1'b0, 1'b0, 32'h10000, 32'h0, 32'hDEADABEF, 1'b0, 1'b0);
        do_access(1, 1'b0, 1'b1, 32'h10002, 32'h0, 32'h000000AB, 1'b0, 1'b0);
        do_access(0, 1'b1, 1'b0, 32'h10001, 32'h11111111, 32'h0, 1'b1, 1'b0);
        do_access(0, 1'b0, 1'b0, 32'h10000, 32'h0, 32'hDEADABEF, 1'b0, 1'b0);
        do_access(1, 1'b0, 1'b0, 32'h10003, 32'h0, 32'h0, 1'b1, 1'b0);
        do_access(0, 1'b1, 1'b0, 32'h10004, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
        do_access(0, 1'b0, 1'b0, 32'h10000, 32'h0, 32'hDEADABEF, 1'b0, 1'b0);

        // Reset during the ACCESS cycle of a write aborts it.
        req      = 2'b01;
        we[0]    = 1'b1;
        byteop[0] = 1'b0;
        addr[0]  = 32'h10004;
        wdata[0] = 32'h12345678;
        @(posedge clk); #1;
        check("abort_gnt_before_rst", gnt, 2'b01);
        rst = 1'b1;
        #1;
        check("abort_mem_we", mem_we, 1'b0);
        check("abort_gnt", gnt, 2'b00);
        @(posedge clk); #1;
        req = '0;
        rst = 1'b0;
        check("abort_rvalid0", rvalid, 2'b00);
        check("abort_rdata_cleared", rdata, 32'h0);
        @(posedge clk); #1;
        check("abort_rvalid1", rvalid, 2'b00);

        // First tie after reset goes to the CPU; old data survives the aborted write.
        we      = '0;
        byteop  = '0;
        addr[0] = 32'h10004;
        addr[1] = 32'h10004;
        req     = 2'b11;
        @(posedge clk); #1;
        check("tie_after_rst_gnt", gnt, 2'b01);
        req = '0;
        @(posedge clk); #1;
        check("tie_after_rst_rvalid", rvalid, 2'b01);
        check("abort_old_value", rdata, 32'hCAFEF00D);
        @(posedge clk); #1;
        check("idle_gnt", gnt, 2'b00);
        check("idle_rvalid", rvalid, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
